// File: rtl/ram_rd_pkg.sv
// ram_rd_pkg: shared state encoding and default geometry for the RAM stream reader
package ram_rd_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_RD_LAT = 2;
    localparam int CNT_W = 16;
endpackage

// File: rtl/ram_stream_reader_if.sv
// ram_stream_reader_if: RAM read port plus the outgoing ready/valid byte stream
interface ram_stream_reader_if
    import ram_rd_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_q;
    logic [DATA_W-1:0] m_data;
    logic m_valid;
    logic m_ready;
    modport master(output ram_addr, m_data, m_valid, input ram_q, m_ready);
    modport slave(input ram_addr, m_data, m_valid, output ram_q, m_ready);
endinterface

// File: rtl/ram_rd_skid_fifo.sv
// ram_rd_skid_fifo: register-array FIFO; pointers wrap by power-of-2 width truncation
module ram_rd_skid_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic clk1,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0] wr, rd;
    always_ff @(posedge clk1 or negedge reset)
        if (!reset) begin
            wr <= '0;
            rd <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr] <= wdata;
                wr <= wr + 1'b1;
            end
            if (pop) rd <= rd + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    assign head = mem[rd];
endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: walks LEN words of the RAM from BASE into a ready/valid byte stream.
// Defining RAM_RD_CNT_EN adds rd_count, a saturating count of words transferred since reset.
module ram_stream_reader
    import ram_rd_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int RD_LAT = DEF_RD_LAT,
    parameter int SKID_DEPTH = 4
) (
    input  logic clk1,
    input  logic reset,
    input  logic start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0] length,
    output logic busy,
    output logic done,
`ifdef RAM_RD_CNT_EN
    output logic [CNT_W-1:0] rd_count,
`endif
    ram_stream_reader_if.master bus
);
    localparam int CW = $clog2(SKID_DEPTH);
    state_t state, state_nx;
    logic [ADDR_W-1:0] addr, cur;
    logic [ADDR_W:0] remaining;
    logic [RD_LAT:0] pipe;
    logic [CW:0] fifo_count;
    logic issue, push, pop;
    int occ;
    assign pop = bus.m_valid & bus.m_ready;
    assign push = pipe[RD_LAT];
    assign bus.m_valid = fifo_count != '0;
    assign busy = state != IDLE;
    assign done = state == FIN;
    assign cur = state == IDLE ? base_addr : addr;
    // pipe covers the ram_addr register plus the RAM's RD_LAT stages; a word leaving now frees its slot
    always_comb begin
        state_nx = state;
        issue = 1'b0;
        occ = $countones(pipe) + int'(fifo_count) - int'(pop);
        case (state)
            IDLE: begin
                issue = start && length != '0;
                state_nx = !start ? IDLE : length == '0 ? FIN : RUN;
            end
            RUN: begin
                issue = remaining != '0 && occ < SKID_DEPTH;
                state_nx = remaining == '0 ? DRAIN : RUN;
            end
            DRAIN: state_nx = occ == 0 ? FIN : DRAIN;
            FIN: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk1 or negedge reset)
        if (!reset) begin
            state <= IDLE;
            addr <= '0;
            remaining <= '0;
            pipe <= '0;
            bus.ram_addr <= '0;
        end else begin
            state <= state_nx;
            pipe <= {pipe[RD_LAT-1:0], issue};
            if (issue) begin
                bus.ram_addr <= cur;
                addr <= cur + 1'b1;
                remaining <= (state == IDLE ? length : remaining) - 1'b1;
            end
        end
    ram_rd_skid_fifo #(.DEPTH(SKID_DEPTH), .WIDTH(DATA_W)) u_fifo (
        .clk1(clk1),
        .reset(reset),
        .push(push),
        .pop(pop),
        .wdata(bus.ram_q),
        .head(bus.m_data),
        .count(fifo_count)
    );
`ifdef RAM_RD_CNT_EN
    always_ff @(posedge clk1 or negedge reset)
        if (!reset) rd_count <= '0;
        else if (pop && rd_count != '1) rd_count <= rd_count + 1'b1;
`endif
endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: behavioural RAM plus a stream-level model checked every cycle
module tb_ram_stream_reader;
    import ram_rd_pkg::*;
    logic clk1 = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic [6:0] base_addr = '0;
    logic [7:0] length = '0;
    logic busy, done;
`ifdef RAM_RD_CNT_EN
    logic [15:0] rd_count;
`endif
    ram_stream_reader_if bus();

    ram_stream_reader dut (
        .clk1(clk1),
        .reset(reset),
        .start(start),
        .base_addr(base_addr),
        .length(length),
        .busy(busy),
        .done(done),
`ifdef RAM_RD_CNT_EN
        .rd_count(rd_count),
`endif
        .bus(bus)
    );

    always #5 clk1 = ~clk1;

    // 128x8 RAM, two-cycle registered read, mem[i] = i ^ A5
    logic [7:0] mem [128];
    logic [6:0] ram_a1;
    initial for (int i = 0; i < 128; i++) mem[i] = 8'(i) ^ 8'hA5;
    always @(posedge clk1) begin
        ram_a1 <= bus.ram_addr;
        bus.ram_q <= mem[ram_a1];
    end

    int checks = 0, errors = 0;
    int issued = 0, accepted = 0, run_len = 0, run_base = 0, since = 0, cnt_model = 0;
    int rmode = 0;
    logic [6:0] prev_addr = '0;
    logic [7:0] hold_data = '0;
    logic [7:0] exp_q[$], got[$];
    bit act = 0, dn = 0, dn_next = 0, first_iss = 0, hold = 0, idle = 1, ready_always = 0;

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, a, e, $time);
        end
    endtask

    always @(negedge clk1) begin
        if (!reset) begin
            chk("rst_busy", 32'(busy), 0);
            chk("rst_done", 32'(done), 0);
            chk("rst_addr", 32'(bus.ram_addr), 0);
            chk("rst_valid", 32'(bus.m_valid), 0);
            chk("rst_data", 32'(bus.m_data), 0);
            act = 0; dn = 0; hold = 0; first_iss = 0; prev_addr = '0;
            issued = 0; accepted = 0; run_len = 0; cnt_model = 0;
            exp_q.delete();
        end else begin
            idle = !act;
            dn_next = 0;
            chk("busy", 32'(busy), 32'(act));
            chk("done", 32'(done), 32'(dn));
`ifdef RAM_RD_CNT_EN
            chk("rd_count", 32'(rd_count), cnt_model);
`endif
            if (first_iss) begin
                chk("first_addr", 32'(bus.ram_addr), run_base);
                issued = 1;
                first_iss = 0;
            end else if (bus.ram_addr != prev_addr) begin
                chk("addr_seq", 32'(bus.ram_addr), (run_base + issued) % 128);
                chk("addr_in_run", 32'(act && issued < run_len), 1);
                issued++;
            end
            prev_addr = bus.ram_addr;
            if (act) begin
                since++;
                chk("outstanding", 32'((issued - accepted) <= 4), 1);
                if (run_len > 0 && since <= 4) chk("latency", 32'(bus.m_valid), 32'(since == 4));
                if (ready_always && since > 4 && exp_q.size() > 0) chk("no_gap", 32'(bus.m_valid), 1);
            end
            chk("no_spurious", 32'(bus.m_valid && exp_q.size() == 0), 0);
            if (hold) begin
                chk("valid_held", 32'(bus.m_valid), 1);
                chk("data_stable", 32'(bus.m_data), 32'(hold_data));
            end
            hold = 0;
            if (bus.m_valid && exp_q.size() > 0) begin
                if (bus.m_ready) begin
                    chk("data", 32'(bus.m_data), 32'(exp_q[0]));
                    got.push_back(bus.m_data);
                    void'(exp_q.pop_front());
                    accepted++;
                    if (cnt_model < 65535) cnt_model++;
                    dn_next = exp_q.size() == 0;
                end else begin
                    hold = 1;
                    hold_data = bus.m_data;
                end
            end
            if (dn) begin
                chk("issued_all", issued, run_len);
                act = 0;
                dn = 0;
            end else if (dn_next) dn = 1;
            if (idle && start) begin
                act = 1; since = 0; issued = 0; accepted = 0;
                run_base = int'(base_addr);
                run_len = int'(length);
                first_iss = length != 0;
                for (int i = 0; i < run_len; i++) exp_q.push_back(mem[(run_base + i) % 128]);
                dn = length == 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk1);
        #1;
        bus.m_ready = rmode == 0 ? 1'b1 : rmode == 1 ? !bus.m_ready :
                      rmode == 3 ? 1'b0 : ($urandom_range(0, 3) != 0);
    endtask

    task automatic kick(input int b, input int l);
        base_addr = 7'(b);
        length = 8'(l);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL timeout: done not seen within %0d cycles", budget);
        end
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        int n;
        logic [6:0] a0;
        bus.m_ready = 1'b0;
        do_reset();
        // 1: basic run
        rmode = 0; ready_always = 1; tick();
        got.delete(); kick(0, 4); wait_done(40);
        chk("t1_n", got.size(), 4);
        chk("t1_w0", 32'(got[0]), 32'hA5); chk("t1_w1", 32'(got[1]), 32'hA4);
        chk("t1_w2", 32'(got[2]), 32'hA7); chk("t1_w3", 32'(got[3]), 32'hA6);
        // 2: address wrap
        got.delete(); kick(126, 4); wait_done(40);
        chk("t2_n", got.size(), 4);
        chk("t2_w0", 32'(got[0]), 32'hDB); chk("t2_w1", 32'(got[1]), 32'hDA);
        chk("t2_w2", 32'(got[2]), 32'hA5); chk("t2_w3", 32'(got[3]), 32'hA4);
        ready_always = 0;
        // 3: alternating backpressure
        rmode = 1; got.delete(); kick(10, 16); wait_done(200);
        chk("t3_n", got.size(), 16);
        chk("t3_first", 32'(got[0]), 32'hAF);
        // stall: issue stops at the skid depth and nothing is lost
        rmode = 3; tick(); got.delete(); kick(20, 12);
        repeat (30) tick();
        chk("stall_issued", issued, 4);
        chk("stall_valid", 32'(bus.m_valid), 1);
        rmode = 1; wait_done(200);
        chk("stall_n", got.size(), 12);
        // 4: zero length
        rmode = 0; a0 = bus.ram_addr; got.delete();
        kick(50, 0); wait_done(10);
        chk("t4_addr", 32'(bus.ram_addr), 32'(a0));
        chk("t4_n", got.size(), 0);
        // 5: reset mid-run
        got.delete(); kick(0, 20);
        n = 0;
        while (got.size() < 5 && n < 100) begin tick(); n++; end
        chk("t5_reached5", got.size(), 5);
        #2 reset = 1'b0;
        #1;
        chk("t5_busy", 32'(busy), 0); chk("t5_done", 32'(done), 0);
        chk("t5_addr", 32'(bus.ram_addr), 0); chk("t5_valid", 32'(bus.m_valid), 0);
        chk("t5_data", 32'(bus.m_data), 0);
        repeat (2) tick();
        reset = 1'b1;
        repeat (3) tick();
        got.delete(); kick(0, 2); wait_done(30);
        chk("t5_n", got.size(), 2);
        chk("t5_w0", 32'(got[0]), 32'hA5); chk("t5_w1", 32'(got[1]), 32'hA4);
        // 6: full-depth runs twice, plus a start while busy
        do_reset();
        rmode = 0; ready_always = 1; tick();
        got.delete(); kick(5, 128);
        repeat (20) tick();
        kick(90, 7);
        wait_done(400);
        kick(0, 128); wait_done(400);
        ready_always = 0;
        chk("t6_n", got.size(), 256);
`ifdef RAM_RD_CNT_EN
        chk("t6_rd_count", 32'(rd_count), 256);
`endif
        // randomized runs
        rmode = 2;
        for (int r = 0; r < 10; r++) begin
            int p, b, l;
            p = $urandom_range(0, 9);
            b = $urandom_range(0, 127);
            l = p == 0 ? 0 : p == 1 ? 128 : $urandom_range(1, 40);
            got.delete(); kick(b, l); wait_done(l * 10 + 60);
            chk("rand_n", got.size(), l);
            repeat ($urandom_range(0, 3)) tick();
        end
        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL global_timeout: bench still running at %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
